// File: rtl/seq_digit_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic bit config_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/seq_digit_adder_if.sv
// Operand/result handshake bundle between a producer/consumer and the adder.
interface seq_digit_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/seq_digit_adder_rca_digit.sv
// Combinational DIGIT-bit ripple-carry slice built from full-adder cells.
module rca_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co    = c[DIGIT];
  // Carry into the top bit; XOR with co gives signed overflow on the last digit.
  assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/seq_digit_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-bit ripple slice reused WIDTH/DIGIT times.
module seq_digit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_digit_adder_if.slave bus
);
  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = $clog2(N) + 1;

  if (!config_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("seq_digit_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT-1:0]       slice_s;
  logic                   slice_co;
  logic                   slice_c_msb;
  logic [WIDTH+DIGIT-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_next;

  rca_digit #(.DIGIT(DIGIT)) u_slice (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_c_msb)
  );

  // New digit enters at the top; after N shifts the LSB digit sits at bit 0.
  assign acc_cat  = {slice_s, acc_q};
  assign acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.cin ^ bus.sub;
            cnt_q   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          acc_q   <= acc_next;
          carry_q <= slice_co;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            // Visible result only updates here, so it holds through IDLE and RUN.
            sum_q  <= acc_next;
            cout_q <= slice_co;
            ovf_q  <= slice_co ^ slice_c_msb;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_digit_adder.sv
// Randomised and directed check of three adder configurations against an arithmetic model.
module tb_seq_digit_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_digit_adder_if #(.WIDTH(16)) if16 ();
  seq_digit_adder_if #(.WIDTH(4))  if4  ();
  seq_digit_adder_if #(.WIDTH(8))  if8  ();

  seq_digit_adder #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rst(rst), .bus(if16.slave));
  seq_digit_adder #(.WIDTH(4),  .DIGIT(4)) u4  (.clk(clk), .rst(rst), .bus(if4.slave));
  seq_digit_adder #(.WIDTH(8),  .DIGIT(1)) u8  (.clk(clk), .rst(rst), .bus(if8.slave));

  // Shared stimulus; sel picks which instance sees in_valid and is observed.
  int          sel;
  logic        in_valid, out_ready, cin, sub;
  logic [15:0] a, b;

  assign if16.in_valid = in_valid && (sel == 0);
  assign if4.in_valid  = in_valid && (sel == 1);
  assign if8.in_valid  = in_valid && (sel == 2);
  assign if16.a = a;       assign if16.b = b;
  assign if4.a  = a[3:0];  assign if4.b  = b[3:0];
  assign if8.a  = a[7:0];  assign if8.b  = b[7:0];
  assign if16.cin = cin;   assign if4.cin = cin;   assign if8.cin = cin;
  assign if16.sub = sub;   assign if4.sub = sub;   assign if8.sub = sub;
  assign if16.out_ready = out_ready;
  assign if4.out_ready  = out_ready;
  assign if8.out_ready  = out_ready;

  logic        m_ir, m_ov, m_cout, m_ovf;
  logic [15:0] m_sum;
  int          m_w, m_n;

  always_comb begin
    m_ir = 1'b0; m_ov = 1'b0; m_cout = 1'b0; m_ovf = 1'b0; m_sum = '0; m_w = 16; m_n = 4;
    case (sel)
      0: begin
        m_ir = if16.in_ready; m_ov = if16.out_valid; m_sum = if16.sum;
        m_cout = if16.cout; m_ovf = if16.overflow; m_w = 16; m_n = 4;
      end
      1: begin
        m_ir = if4.in_ready; m_ov = if4.out_valid; m_sum = 16'(if4.sum);
        m_cout = if4.cout; m_ovf = if4.overflow; m_w = 4; m_n = 1;
      end
      default: begin
        m_ir = if8.in_ready; m_ov = if8.out_valid; m_sum = 16'(if8.sum);
        m_cout = if8.cout; m_ovf = if8.overflow; m_w = 8; m_n = 8;
      end
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t sel=%0d)", name, act, exp, $time, sel);
    end
  endtask

  // Reference: plain integer arithmetic modulo 2^w.
  function automatic void model(input int w, input logic [15:0] x, input logic [15:0] y,
                                input logic ci, input logic sb,
                                output logic [15:0] s, output logic co, output logic ov);
    logic [16:0] mask, xx, yy, full;
    mask = (17'd1 << w) - 17'd1;
    xx   = {1'b0, x} & mask;
    yy   = sb ? (~{1'b0, y} & mask) : ({1'b0, y} & mask);
    full = xx + yy + 17'(sb ? !ci : ci);
    s    = full[15:0] & mask[15:0];
    co   = full[w];
    ov   = (xx[w-1] == yy[w-1]) && (s[w-1] != xx[w-1]);
  endfunction

  typedef struct {
    bit          pending;
    bit          seen;
    int          k;
    logic [15:0] es;
    logic        ec, eo;
  } mon_t;
  mon_t mon = '{pending: 0, seen: 0, k: 0, es: 0, ec: 0, eo: 0};

  // Single compare process: latency, result and stall behaviour every cycle.
  always @(negedge clk) begin
    if (rst) begin
      mon.pending = 0;
    end else begin
      if (mon.pending) begin
        mon.k++;
        if (m_ov) begin
          if (!mon.seen) begin
            check("latency", 32'(mon.k), 32'(m_n));
            mon.seen = 1;
          end
          check("sum", 32'(m_sum), 32'(mon.es));
          check("cout", 32'(m_cout), 32'(mon.ec));
          check("overflow", 32'(m_ovf), 32'(mon.eo));
          check("in_ready_in_done", 32'(m_ir), 32'd0);
          if (out_ready) mon.pending = 0;
        end else if (mon.k > m_n) begin
          check("latency_timeout", 32'(mon.k), 32'(m_n));
          mon.pending = 0;
        end
      end else begin
        check("spurious_out_valid", 32'(m_ov), 32'd0);
      end
      if (in_valid && m_ir) begin
        model(m_w, a, b, cin, sub, mon.es, mon.ec, mon.eo);
        mon.pending = 1;
        mon.seen    = 0;
        mon.k       = -1;
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
    int t = 0;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (m_ir) break;
      if (++t > 100) begin check("accept_timeout", 32'(t), 32'd0); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int t = 0;
    forever begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (m_ov && out_ready) break;
      if (++t > 300) begin check("done_timeout", 32'(t), 32'd0); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  task automatic op_lit(input string name, input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic sb,
                        input logic [15:0] es, input logic ec, input logic eo);
    send(x, y, ci, sb);
    wait_done(1'b0);
    check({name, "_sum"}, 32'(m_sum), 32'(es));
    check({name, "_cout"}, 32'(m_cout), 32'(ec));
    check({name, "_ovf"}, 32'(m_ovf), 32'(eo));
  endtask

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check("rst_in_ready", 32'(m_ir), 32'd1);
      check("rst_out_valid", 32'(m_ov), 32'd0);
      check("rst_sum", 32'(m_sum), 32'd0);
      check("rst_flags", 32'({m_cout, m_ovf}), 32'd0);
    end
    sel = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Hand-computed corners pin the model.
    op_lit("add",      16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    op_lit("carry",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op_lit("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op_lit("sub",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op_lit("ovf_sub",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    op_lit("borrow",   16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

    // Backpressure: hold DONE for 5 cycles while in_valid toggles.
    out_ready = 1'b0;
    send(16'h0102, 16'h0304, 1'b0, 1'b0);
    t = 0;
    forever begin
      @(negedge clk);
      if (m_ov) break;
      if (++t > 50) begin check("bp_timeout", 32'(t), 32'd0); break; end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = 16'($urandom);
      @(posedge clk); #1;
    end
    check("bp_held_sum", 32'(m_sum), 32'h0406);
    check("bp_held_valid", 32'(m_ov), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_back_idle", 32'(m_ir), 32'd1);
    op_lit("after_bp", 16'h00A0, 16'h0B00, 1'b1, 1'b0, 16'h0BA1, 1'b0, 1'b0);

    // Reset after two RUN cycles aborts the operation.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrun_out_valid", 32'(m_ov), 32'd0);
    check("midrun_in_ready", 32'(m_ir), 32'd1);
    check("midrun_sum", 32'(m_sum), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    op_lit("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Random add/sub with random backpressure, 16/4.
    for (int i = 0; i < 150; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      wait_done(1'b1);
    end

    // Exhaustive 4/4 adds: single-cycle latency.
    sel = 1;
    @(posedge clk); #1;
    op_lit("w4_lit", 16'h0009, 16'h0008, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1);
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      send({12'd0, v[8:5]}, {12'd0, v[4:1]}, v[0], 1'b0);
      wait_done(1'b0);
    end

    // Random add/sub, 8/1: eight-cycle latency.
    sel = 2;
    @(posedge clk); #1;
    op_lit("w8_lit", 16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1);
    for (int i = 0; i < 150; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      wait_done(1'b1);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_digit_adder.md
# seq_digit_adder

Parametrised multi-cycle ripple adder/subtractor. Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, so one small ripple slice is reused across N = WIDTH/DIGIT cycles. Inputs and outputs use valid/ready handshakes, and the block reports carry and signed overflow. It sits where wide operands need a narrow, area-cheap adder and the multi-cycle latency is tolerable.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (subtract).
- sub  input  1  0 = a+b+cin, 1 = a−b−cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of MSB (in subtract mode 0 = borrow occurred).
- overflow  output  1  two's-complement overflow.

## Operation
- FSM states are IDLE, RUN and DONE; reset forces IDLE.
- IDLE: in_ready=1. When in_valid&in_ready, the block:
  - latches a;
  - latches b^{WIDTH{sub}};
  - loads the carry register with cin^sub;
  - clears the digit counter;
  - goes to RUN.
- RUN: each cycle adds the low DIGIT bits of the A/B shift registers plus the carry register. It then:
  - shifts the DIGIT-bit result into the top of the sum register;
  - shifts A/B right by DIGIT;
  - stores the slice carry-out;
  - increments the counter.
- RUN, final digit: on the N-th RUN cycle the block captures cout (slice carry-out) and overflow (carry into MSB XOR carry out of MSB), then goes to DONE.
- DONE: out_valid=1, and sum/cout/overflow are held stable. On out_ready the block returns to IDLE.
- in_ready is 0 in RUN and DONE. in_valid is ignored there, with no queuing.
- Operands change freely after acceptance; only the latched copies are used.
- Arithmetic is modulo 2^WIDTH. Subtract is a + ~b + ~cin, so cin=1 in subtract mode borrows one.
- Reset mid-RUN or mid-DONE aborts the operation and the result is lost.
- Reset values:
  - in_ready=1;
  - out_valid=0;
  - sum=0;
  - cout=0;
  - overflow=0;
  - all internal registers are 0.
- sum, cout and overflow hold their last values in IDLE until the next DONE.

## Timing
- All outputs are registered except in_ready and out_valid, which decode directly from the state register.
- Acceptance edge is T. RUN edges are T+1..T+N. out_valid is high from just after edge T+N.
- Latency is N cycles from the acceptance edge to out_valid.
- Minimum initiation interval is N+2 cycles when out_ready is held high: N RUN cycles, one DONE cycle, one IDLE cycle.
- When DIGIT=WIDTH, N=1 and the block is a single-cycle registered adder with handshake.
- Counter width is $clog2(N)+1.
- Critical path is one DIGIT-bit ripple, independent of WIDTH.

## Structure
- Shared package adder_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - a constant function num_digits(WIDTH, DIGIT);
  - an elaboration check that WIDTH % DIGIT == 0.
- Sub-module rca_digit is a combinational DIGIT-bit ripple slice built from full-adder cells.
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: s[DIGIT], co, c_msb (carry into the top bit, used for overflow).
- Top level holds the FSM, the A/B/sum shift registers, the carry register and the counter.

## Test plan
- Add (WIDTH=16, DIGIT=4): a=0x1234, b=0x4321, cin=0, sub=0 → sum=0x5555, cout=0, overflow=0, with out_valid exactly 4 cycles after acceptance.
- Carry/overflow corners (sub=0):
  - 0xFFFF+0x0001 → sum=0x0000, cout=1, overflow=0.
  - 0x7FFF+0x0001 → sum=0x8000, cout=0, overflow=1.
- Subtract (sub=1):
  - a=0x0005, b=0x0007, cin=0 → sum=0xFFFE, cout=0, overflow=0.
  - a=0x8000, b=0x0001, cin=0 → sum=0x7FFF, overflow=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0, and a toggling in_valid is ignored.
  - Then out_ready=1 → IDLE next cycle, and a new operation is accepted.
- Reset mid-RUN: assert rst after 2 RUN cycles → immediately out_valid=0, in_ready=1, sum=0. The next operation 0x00FF+0x0001 yields 0x0100.
- Configurations:
  - WIDTH=4, DIGIT=4: exhaustive 512 {a,b,cin} adds with 1-cycle latency, matching the reference model.
  - WIDTH=8, DIGIT=1: random add/sub against a model, with 8-cycle latency.
